// File: rtl/enc_pkg.sv
// Shared widths, code type and the priority function for the 9-line inverted-BCD encoder.
package enc_pkg;

    localparam int N_LINES = 9;
    localparam int CODE_W  = 4;

    typedef logic [CODE_W-1:0] bcd_t;

    // Scan from the top line down; the first low line sets the value. All-high returns 0.
    function automatic bcd_t prio_bcd(logic [N_LINES-1:0] req_n);
        bcd_t d;
        logic found;
        d     = '0;
        found = 1'b0;
        for (int k = N_LINES - 1; k >= 0; k--) begin
            if (!found && !req_n[k]) begin
                d     = CODE_W'(k + 1);
                found = 1'b1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/encoder_0_comb.sv
// Combinational part of the encoder: priority pick and output inversion.
module encoder_0_comb
    import enc_pkg::*;
(
    input  logic [N_LINES-1:0] I_n,
    output bcd_t               code_n
);

    assign code_n = ~prio_bcd(I_n);

endmodule

// File: rtl/encoder_0.sv
// Registered 9-to-4 inverted-BCD priority encoder (74x147 behaviour, one cycle latency).
module encoder_0
    import enc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LINES-1:0] I_n,
    output bcd_t               Y_n
);

    bcd_t code_next;

    encoder_0_comb u_comb (
        .I_n    (I_n),
        .code_n (code_next)
    );

    // All-ones is the "no request" code, so reset lands on a legal output value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y_n <= '1;
        end else begin
            Y_n <= code_next;
        end
    end

endmodule

// File: tb/tb_encoder_0.sv
// Directed bench for encoder_0: reset, priority table, walking zero, latency and async reset.
module tb_encoder_0;

    logic       clk;
    logic       rst;
    logic [8:0] I_n;
    logic [3:0] Y_n;

    int total = 0;
    int bad   = 0;
    logic [3:0] prev_exp;

    encoder_0 dut (
        .clk (clk),
        .rst (rst),
        .I_n (I_n),
        .Y_n (Y_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end else begin
            $display("ok   %s: Y_n=%b", tag, got);
        end
    endtask

    // Change I_n at a falling edge; Y_n must hold until the next rising edge, then update.
    task automatic apply(input logic [8:0] v, input logic [3:0] e, input string tag);
        @(negedge clk);
        I_n = v;
        #1 chk({tag, "_hold"}, Y_n, prev_exp);
        @(posedge clk);
        #1 chk(tag, Y_n, e);
        prev_exp = e;
    endtask

    initial begin
        rst = 1'b1;
        I_n = 9'h1FF;
        #2 chk("reset_init", Y_n, 4'b1111);
        #1 I_n = 9'b000000000;
        #1 chk("reset_no_edge", Y_n, 4'b1111);
        @(posedge clk);
        #1 chk("reset_edge_held", Y_n, 4'b1111);
        @(negedge clk);
        rst = 1'b0;
        I_n = 9'h1FF;
        prev_exp = 4'b1111;

        apply(9'b101010000, 4'b0111, "dec8");
        apply(9'b111010000, 4'b1001, "dec6");
        apply(9'b111111100, 4'b1101, "dec2");
        apply(9'b111111111, 4'b1111, "dec0");

        apply(9'b111111110, 4'b1110, "walk1");
        apply(9'b111111101, 4'b1101, "walk2");
        apply(9'b111111011, 4'b1100, "walk3");
        apply(9'b111110111, 4'b1011, "walk4");
        apply(9'b111101111, 4'b1010, "walk5");
        apply(9'b111011111, 4'b1001, "walk6");
        apply(9'b110111111, 4'b1000, "walk7");
        apply(9'b101111111, 4'b0111, "walk8");
        apply(9'b011111111, 4'b0110, "walk9");
        apply(9'b000000000, 4'b0110, "all_low");

        // Mid-cycle reset must act without waiting for a clock edge.
        #2 rst = 1'b1;
        #1 chk("mid_reset_async", Y_n, 4'b1111);
        @(posedge clk);
        #1 chk("mid_reset_edge", Y_n, 4'b1111);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("release_hold", Y_n, 4'b1111);
        @(posedge clk);
        #1 chk("release_reload", Y_n, 4'b0110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
